// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI peripheral endpoint: FSM state encoding and
// the width helper used across the SPI code.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } spi_state_e;

  // Number of bits needed to count 0 .. value-1 (ceil(log2(value))).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Synchronizer chain plus history flop for an asynchronous pin, with registered
// single-cycle rise/fall strobes aligned to the synchronized level output.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  logic              rise_q;
  logic              fall_q;

  // Level and strobes share one clock of latency past the chain, keeping pins mutually ordered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      hist_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~hist_q;
      fall_q <= ~sync_q[STAGES-1] & hist_q;
    end
  end

  assign level_o = hist_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI peripheral endpoint (ss active-low, sclk idle low, MSB first): oversamples
// the pins in the clk domain, shifts a frame in on mosi and a buffered word out on miso.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int BITS        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sclk,
  input  logic            ss,
  input  logic            mosi,
  output logic            miso,
  input  logic [BITS-1:0] tx_data,
  input  logic            tx_load,
  output logic            tx_ready,
  output logic [BITS-1:0] rx_data,
  output logic            rx_valid,
  output logic            tx_underrun,
  output logic            frm_err,
  output logic            busy
);

  localparam int                 CNT_W    = clogb2(BITS + 1);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(BITS - 1);

  logic sck_rise_s;
  logic sck_fall_s;
  logic ss_rise_s;
  logic ss_fall_s;
  logic mosi_s;
  logic sclk_lvl_unused;
  logic ss_lvl_unused;
  logic [1:0] mosi_edge_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .rst     (rst),
    .async_i (sclk),
    .level_o (sclk_lvl_unused),
    .rise_o  (sck_rise_s),
    .fall_o  (sck_fall_s)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk     (clk),
    .rst     (rst),
    .async_i (ss),
    .level_o (ss_lvl_unused),
    .rise_o  (ss_rise_s),
    .fall_o  (ss_fall_s)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .rst     (rst),
    .async_i (mosi),
    .level_o (mosi_s),
    .rise_o  (mosi_edge_unused[0]),
    .fall_o  (mosi_edge_unused[1])
  );

  spi_state_e        state_q;
  logic [BITS-1:0]   tx_buf_q;
  logic              tx_ready_q;
  logic [BITS-2:0]   shr_q;
  logic [BITS-2:0]   rx_sh_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BITS-1:0]   rx_data_q;
  logic              rx_valid_q;
  logic              tx_underrun_q;
  logic              frm_err_q;
  logic              miso_q;
  logic              busy_q;
  logic              frame_start_s;
  logic [BITS-1:0]   rx_next_s;

  assign frame_start_s = (state_q == ST_IDLE) && ss_fall_s;
  assign rx_next_s     = {rx_sh_q, mosi_s};

  // A load coinciding with frame start refills the buffer for the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_buf_q   <= '0;
      tx_ready_q <= 1'b1;
    end else if (tx_load && (tx_ready_q || frame_start_s)) begin
      tx_buf_q   <= tx_data;
      tx_ready_q <= 1'b0;
    end else if (frame_start_s) begin
      tx_ready_q <= 1'b1;
    end else begin
      tx_ready_q <= tx_ready_q;
    end
  end

  // Frame FSM; miso_q carries the current MSB, shr_q the bits still to send.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      shr_q         <= '0;
      rx_sh_q       <= '0;
      cnt_q         <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frm_err_q     <= 1'b0;
      miso_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frm_err_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ss_fall_s) begin
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            rx_sh_q <= '0;
            if (tx_ready_q) begin
              shr_q         <= '0;
              miso_q        <= 1'b0;
              tx_underrun_q <= 1'b1;
            end else begin
              shr_q  <= tx_buf_q[BITS-2:0];
              miso_q <= tx_buf_q[BITS-1];
            end
          end else begin
            miso_q <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // ss_rise wins over a coincident sclk edge.
          if (ss_rise_s) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            miso_q    <= 1'b0;
            frm_err_q <= 1'b1;
          end else if (sck_rise_s) begin
            rx_sh_q <= rx_next_s[BITS-2:0];
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              rx_data_q  <= rx_next_s;
              rx_valid_q <= 1'b1;
              state_q    <= ST_HOLD;
              miso_q     <= 1'b0;
            end else begin
              miso_q <= miso_q;
            end
          end else if (sck_fall_s) begin
            miso_q <= shr_q[BITS-2];
            shr_q  <= shr_q << 1;
          end else begin
            miso_q <= miso_q;
          end
        end
        ST_HOLD: begin
          miso_q <= 1'b0;
          if (ss_rise_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          miso_q  <= 1'b0;
        end
      endcase
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frm_err     = frm_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed frame table, hand sequences for
// load/reset corners, and randomized frames against a frame-level model.
module tb_spi_slave;

  localparam int BITS = 8;
  localparam int HALF = 20;

  logic            clk = 1'b0;
  logic            rst;
  logic            sclk;
  logic            ss;
  logic            mosi;
  logic            miso;
  logic [BITS-1:0] tx_data;
  logic            tx_load;
  logic            tx_ready;
  logic [BITS-1:0] rx_data;
  logic            rx_valid;
  logic            tx_underrun;
  logic            frm_err;
  logic            busy;

  always #5 clk = ~clk;

  spi_slave #(.BITS(BITS), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .ss          (ss),
    .mosi        (mosi),
    .miso        (miso),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .frm_err     (frm_err),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_und = 0;
  int n_frm = 0;

  always @(posedge clk) begin
    if (rx_valid)    n_valid <= n_valid + 1;
    if (tx_underrun) n_und   <= n_und + 1;
    if (frm_err)     n_frm   <= n_frm + 1;
  end

  // Frame-level reference model: one-deep tx buffer and last received word.
  logic            m_pending;
  logic [BITS-1:0] m_buf;
  logic [BITS-1:0] m_rx;

  typedef struct {
    logic            load;
    logic [BITS-1:0] txw;
    logic [BITS-1:0] mw;
    int              np;
    logic [BITS-1:0] erx;
    logic [9:0]      emiso;
    int              ev;
    int              eu;
    int              ef;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [BITS-1:0] w);
    tx_data = w;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    if (!m_pending) begin
      m_pending = 1'b1;
      m_buf     = w;
    end
    chk("tx_ready_after_load", 32'(tx_ready), 32'd0);
  endtask

  task automatic model_frame(input logic [BITS-1:0] mw, input int np,
                             input bit load_at_start, input logic [BITS-1:0] ld,
                             output logic [9:0] em, output int ev, output int eu, output int ef);
    logic [BITS-1:0] word;
    word = m_pending ? m_buf : '0;
    eu   = m_pending ? 0 : 1;
    m_pending = 1'b0;
    if (load_at_start) begin
      m_pending = 1'b1;
      m_buf     = ld;
    end
    em = '0;
    for (int i = 0; i < np; i++) begin
      em[9-i] = (i < BITS) ? word[BITS-1-i] : 1'b0;
    end
    if (np >= BITS) begin
      ev = 1; ef = 0; m_rx = mw;
    end else begin
      ev = 0; ef = 1;
    end
  endtask

  task automatic run_frame(input logic [BITS-1:0] mw, input int np,
                           input bit load_at_start, input logic [BITS-1:0] ld,
                           output logic [9:0] got, output int dv, output int du, output int df);
    int v0, u0, f0;
    v0 = n_valid; u0 = n_und; f0 = n_frm;
    got = '0;
    ss = 1'b0;
    if (load_at_start) begin
      tx_data = ld;
      tx_load = 1'b1;
      tick(8);
      tx_load = 1'b0;
      chk("tx_ready_load_at_start", 32'(tx_ready), 32'd0);
    end else begin
      tick(8);
      chk("tx_ready_at_ss_fall", 32'(tx_ready), 32'd1);
    end
    chk("busy_in_frame", 32'(busy), 32'd1);
    for (int i = 0; i < np; i++) begin
      mosi = (i < BITS) ? mw[BITS-1-i] : 1'($urandom_range(0, 1));
      tick(HALF);
      if (i < 10) got[9-i] = miso;
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    tick(HALF);
    ss = 1'b1;
    tick(8);
    chk("busy_after_frame", 32'(busy), 32'd0);
    dv = n_valid - v0;
    du = n_und - u0;
    df = n_frm - f0;
  endtask

  task automatic check_frame(input int np, input logic [9:0] got, input logic [9:0] em,
                             input int dv, input int du, input int df,
                             input int ev, input int eu, input int ef, input logic [BITS-1:0] erx);
    logic [9:0] mask;
    mask = 10'h3FF << (10 - np);
    chk("miso_bits", 32'(got & mask), 32'(em & mask));
    chk("rx_valid_count", 32'(dv), 32'(ev));
    chk("tx_underrun_count", 32'(du), 32'(eu));
    chk("frm_err_count", 32'(df), 32'(ef));
    chk("rx_data", 32'(rx_data), 32'(erx));
  endtask

  initial begin
    logic [9:0]      got;
    logic [9:0]      em;
    int              dv, du, df, ev, eu, ef;
    logic [BITS-1:0] mw;
    int              np;
    int              r;
    int              f0;

    tbl[0] = '{1'b1, 8'hA5, 8'h3C, 8,  8'h3C, 10'h294, 1, 0, 0};
    tbl[1] = '{1'b0, 8'h00, 8'h5A, 8,  8'h5A, 10'h000, 1, 1, 0};
    tbl[2] = '{1'b1, 8'h0F, 8'hFF, 5,  8'h5A, 10'h020, 0, 0, 1};
    tbl[3] = '{1'b0, 8'h00, 8'h81, 8,  8'h81, 10'h000, 1, 1, 0};
    tbl[4] = '{1'b1, 8'hC3, 8'h96, 10, 8'h96, 10'h30C, 1, 0, 0};

    m_pending = 1'b0; m_buf = '0; m_rx = '0;
    rst = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0; tx_data = '0; tx_load = 1'b0;
    tick(3);
    chk("reset_miso", 32'(miso), 32'd0);
    chk("reset_tx_ready", 32'(tx_ready), 32'd1);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_flags", 32'({tx_underrun, frm_err}), 32'd0);
    rst = 1'b0;
    tick(5);

    // Directed frame table
    for (int k = 0; k < 5; k++) begin
      if (tbl[k].load) do_load(tbl[k].txw);
      model_frame(tbl[k].mw, tbl[k].np, 1'b0, '0, em, ev, eu, ef);
      run_frame(tbl[k].mw, tbl[k].np, 1'b0, '0, got, dv, du, df);
      check_frame(tbl[k].np, got, tbl[k].emiso, dv, du, df,
                  tbl[k].ev, tbl[k].eu, tbl[k].ef, tbl[k].erx);
    end

    // Load coinciding with frame start while the buffer is full, then a dropped load
    do_load(8'h11);
    model_frame(8'h22, 8, 1'b1, 8'h99, em, ev, eu, ef);
    run_frame(8'h22, 8, 1'b1, 8'h99, got, dv, du, df);
    check_frame(8, got, em, dv, du, df, ev, eu, ef, m_rx);
    chk("tx_ready_buffer_refilled", 32'(tx_ready), 32'd0);
    do_load(8'h44);
    model_frame(8'h3D, 8, 1'b0, '0, em, ev, eu, ef);
    run_frame(8'h3D, 8, 1'b0, '0, got, dv, du, df);
    check_frame(8, got, em, dv, du, df, ev, eu, ef, m_rx);

    // Reset after four bits of a frame
    do_load(8'h5E);
    f0 = n_frm;
    ss = 1'b0;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      mosi = 1'($urandom_range(0, 1));
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    tick(HALF);
    rst = 1'b1;
    #1;
    chk("midrst_miso", 32'(miso), 32'd0);
    chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
    chk("midrst_rx_data", 32'(rx_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pulses", 32'({rx_valid, tx_underrun, frm_err}), 32'd0);
    m_pending = 1'b0; m_rx = '0;
    ss = 1'b1; sclk = 1'b0;
    tick(5);
    rst = 1'b0;
    tick(8);
    chk("midrst_no_frm_err", 32'(n_frm - f0), 32'd0);
    do_load(8'hB7);
    model_frame(8'h69, 8, 1'b0, '0, em, ev, eu, ef);
    run_frame(8'h69, 8, 1'b0, '0, got, dv, du, df);
    check_frame(8, got, em, dv, du, df, ev, eu, ef, m_rx);

    // Randomized frames
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 2) != 0) do_load(8'($urandom));
      if ($urandom_range(0, 4) == 0) do_load(8'($urandom));
      r = $urandom_range(0, 3);
      np = (r == 0) ? $urandom_range(2, 7) : ((r == 3) ? $urandom_range(9, 10) : 8);
      mw = 8'($urandom);
      model_frame(mw, np, 1'b0, '0, em, ev, eu, ef);
      run_frame(mw, np, 1'b0, '0, got, dv, du, df);
      check_frame(np, got, em, dv, du, df, ev, eu, ef, m_rx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
